sparse_weight_compressor: RTL and testbench



---
 rtl/sparse_weight_compressor.sv | 250 +++++++++++++++++++++++++
 tb/tb_sparse_weight_compressor.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_weight_compressor.sv
// sparse_weight_compressor: prunes dense groups of n unsigned weights down to
// the nnz largest, packs them by ascending index with a keep bitmask, and
// queues the result in a first-word-fall-through FIFO. Upstream flow control
// is credit based, so the two pipeline stages never stall.
module sparse_weight_compressor #(
  parameter int bw         = 4,
  parameter int nnz        = 2,
  parameter int n          = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_BW     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [n*bw-1:0]       dense_flat,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [nnz*bw-1:0]     weights_flat,
  output logic [n-1:0]          w_index,
  output logic                  out_last,
  output logic [CNT_BW-1:0]     dropped_nz,
  output logic                  busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam int NZ_W  = $clog2(n + 1);
  localparam int ENT_W = nnz * bw + n + 1;

  // Keep mask: a position survives when fewer than nnz positions outrank it.
  // A position is outranked by a strictly larger weight, or by an equal
  // weight at a lower index, so ties always resolve toward index 0.
  function automatic logic [n-1:0] f_keep_mask(input logic [n*bw-1:0] d);
    logic [n-1:0] m;
    int           rank;
    m = '0;
    for (int k = 0; k < n; k++) begin
      rank = 0;
      for (int j = 0; j < n; j++) begin
        if ((d[j*bw +: bw] > d[k*bw +: bw]) ||
            ((d[j*bw +: bw] == d[k*bw +: bw]) && (j < k))) begin
          rank = rank + 1;
        end else begin
          rank = rank;
        end
      end
      m[k] = (rank < nnz);
    end
    return m;
  endfunction

  // Pack kept weights into consecutive fields, lowest kept index first.
  function automatic logic [nnz*bw-1:0] f_pack(input logic [n*bw-1:0] d,
                                               input logic [n-1:0]    m);
    logic [nnz*bw-1:0] p;
    int                slot;
    p    = '0;
    slot = 0;
    for (int k = 0; k < n; k++) begin
      if (m[k] && (slot < nnz)) begin
        p[slot*bw +: bw] = d[k*bw +: bw];
        slot             = slot + 1;
      end else begin
        slot = slot;
      end
    end
    return p;
  endfunction

  // Number of nonzero weights that the mask throws away.
  function automatic logic [NZ_W-1:0] f_nz_dropped(input logic [n*bw-1:0] d,
                                                   input logic [n-1:0]    m);
    logic [NZ_W-1:0] c;
    c = '0;
    for (int k = 0; k < n; k++) begin
      if (!m[k] && (d[k*bw +: bw] != {bw{1'b0}})) begin
        c = c + NZ_W'(1);
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  // Stage S1 state
  logic              r_s1_valid;
  logic [n*bw-1:0]   r_s1_dense;
  logic              r_s1_last;

  // Stage S2 state
  logic              r_s2_valid;
  logic [nnz*bw-1:0] r_s2_weights;
  logic [n-1:0]      r_s2_index;
  logic              r_s2_last;
  logic [NZ_W-1:0]   r_s2_nz;

  // Output FIFO state
  logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [OCC_W-1:0]  r_occ;

  logic [CNT_BW-1:0] r_dropped;

  // Combinational helpers
  logic              w_in_fire;
  logic              w_push;
  logic              w_pop;
  logic [OCC_W:0]    w_credit_sum;
  logic [n-1:0]      w_s1_mask;
  logic [nnz*bw-1:0] w_s1_pack;
  logic [NZ_W-1:0]   w_s1_nz;
  logic [CNT_BW:0]   w_cnt_sum;
  logic [CNT_BW-1:0] w_cnt_next;
  logic [OCC_W-1:0]  w_occ_next;

  // Credit check counts every group already committed downstream; an output
  // transfer this cycle only frees a credit once the occupancy register drops.
  always_comb begin
    w_credit_sum = {1'b0, r_occ} + (OCC_W+1)'(r_s1_valid) + (OCC_W+1)'(r_s2_valid);
    in_ready     = (w_credit_sum < (OCC_W+1)'(FIFO_DEPTH));
    w_in_fire    = in_valid && in_ready;
    out_valid    = (r_occ != '0);
    w_pop        = out_valid && out_ready;
    w_push       = r_s2_valid;
    busy         = r_s1_valid || r_s2_valid || (r_occ != '0);
    dropped_nz   = r_dropped;
  end

  // Rank and pack the captured group ahead of the S2 register.
  always_comb begin
    w_s1_mask = f_keep_mask(r_s1_dense);
    w_s1_pack = f_pack(r_s1_dense, w_s1_mask);
    w_s1_nz   = f_nz_dropped(r_s1_dense, w_s1_mask);
  end

  // Stage S1: capture the dense group on an input transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_dense <= '0;
      r_s1_last  <= 1'b0;
    end else begin
      r_s1_valid <= w_in_fire;
      if (w_in_fire) begin
        r_s1_dense <= dense_flat;
        r_s1_last  <= in_last;
      end else begin
        r_s1_dense <= r_s1_dense;
        r_s1_last  <= r_s1_last;
      end
    end
  end

  // Stage S2: register the packed result; it moves into the FIFO next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid   <= 1'b0;
      r_s2_weights <= '0;
      r_s2_index   <= '0;
      r_s2_last    <= 1'b0;
      r_s2_nz      <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_weights <= w_s1_pack;
        r_s2_index   <= w_s1_mask;
        r_s2_last    <= r_s1_last;
        r_s2_nz      <= w_s1_nz;
      end else begin
        r_s2_weights <= r_s2_weights;
        r_s2_index   <= r_s2_index;
        r_s2_last    <= r_s2_last;
        r_s2_nz      <= r_s2_nz;
      end
    end
  end

  // Saturating add of the dropped-nonzero count for the group entering the FIFO.
  always_comb begin
    w_cnt_sum = {1'b0, r_dropped} + (CNT_BW+1)'(r_s2_nz);
    if (w_cnt_sum[CNT_BW]) begin
      w_cnt_next = '1;
    end else begin
      w_cnt_next = w_cnt_sum[CNT_BW-1:0];
    end
  end

  // Dropped-nonzero counter, advanced only when an S2 result is written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dropped <= '0;
    end else if (w_push) begin
      r_dropped <= w_cnt_next;
    end else begin
      r_dropped <= r_dropped;
    end
  end

  // Next occupancy; simultaneous write and read leaves it unchanged.
  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_occ_next = r_occ + OCC_W'(1);
      2'b01:   w_occ_next = r_occ - OCC_W'(1);
      default: w_occ_next = r_occ;
    endcase
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      r_occ <= w_occ_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
    end
  end

  // FIFO storage; contents are don't-care until written, outputs gate on occupancy.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_s2_weights, r_s2_index, r_s2_last};
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // Head of the FIFO drives the outputs; an empty FIFO presents zeros.
  always_comb begin
    if (r_occ != '0) begin
      {weights_flat, w_index, out_last} = r_mem[r_rd_ptr];
    end else begin
      {weights_flat, w_index, out_last} = '0;
    end
  end

endmodule

// File: tb/tb_sparse_weight_compressor.sv
// Self-checking bench for sparse_weight_compressor. A queue-based model
// chooses the two largest weights per group directly, tracks in-flight groups
// by acceptance time, and is compared against the DUT on every falling edge.
// A second instance with a 2-bit counter shares all stimulus to exercise
// saturation of the dropped-nonzero count.
module tb_sparse_weight_compressor;

  localparam int DEPTH = 4;

  logic        clk        = 1'b0;
  logic        reset      = 1'b0;
  logic        in_valid   = 1'b0;
  logic [15:0] dense_flat = 16'h0000;
  logic        in_last    = 1'b0;
  logic        out_ready  = 1'b1;

  logic        in_ready, out_valid, out_last, busy;
  logic [7:0]  weights_flat;
  logic [3:0]  w_index;
  logic [15:0] dropped_nz;

  logic        s_in_ready, s_out_valid, s_out_last, s_busy;
  logic [7:0]  s_weights_flat;
  logic [3:0]  s_w_index;
  logic [1:0]  s_dropped_nz;

  sparse_weight_compressor #(.bw(4), .nnz(2), .n(4), .FIFO_DEPTH(DEPTH), .CNT_BW(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .dense_flat(dense_flat), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .weights_flat(weights_flat), .w_index(w_index),
    .out_last(out_last), .dropped_nz(dropped_nz), .busy(busy)
  );

  sparse_weight_compressor #(.bw(4), .nnz(2), .n(4), .FIFO_DEPTH(DEPTH), .CNT_BW(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .dense_flat(dense_flat), .in_last(in_last), .out_valid(s_out_valid),
    .out_ready(out_ready), .weights_flat(s_weights_flat), .w_index(s_w_index),
    .out_last(s_out_last), .dropped_nz(s_dropped_nz), .busy(s_busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] wts; logic [3:0] idx; logic last; } ent_t;
  typedef struct { logic [15:0] d; logic last; int t; } fl_t;

  ent_t mf[$];
  fl_t  fl[$];
  int   cyc    = 0;
  int   m_d16  = 0;
  int   m_d2   = 0;
  int   errors = 0;
  int   checks = 0;
  int   n_out  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Two largest weights; scanning upward with strict '>' favours the lower index.
  function automatic ent_t model_group(input logic [15:0] d, input logic l);
    logic [3:0] w [4];
    int a, b, lo, hi;
    ent_t e;
    for (int k = 0; k < 4; k++) w[k] = d[k*4 +: 4];
    a = 0;
    for (int k = 1; k < 4; k++) if (w[k] > w[a]) a = k;
    b = -1;
    for (int k = 0; k < 4; k++) begin
      if (k != a) begin
        if (b < 0) b = k;
        else if (w[k] > w[b]) b = k;
      end
    end
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    e.wts = {w[hi], w[lo]};
    e.idx = 4'b0000;
    e.idx[a] = 1'b1;
    e.idx[b] = 1'b1;
    e.last = l;
    return e;
  endfunction

  function automatic int model_drops(input logic [15:0] d);
    ent_t e;
    int c;
    e = model_group(d, 1'b0);
    c = 0;
    for (int k = 0; k < 4; k++) if (!e.idx[k] && (d[k*4 +: 4] != 4'h0)) c++;
    return c;
  endfunction

  function automatic bit m_in_ready();
    return (mf.size() + fl.size()) < DEPTH;
  endfunction

  // Model state advance: decisions use pre-edge occupancy, then apply.
  always @(posedge clk or posedge reset) begin : mdl
    bit   acc, pop;
    ent_t e;
    int   dr;
    if (reset) begin
      mf.delete();
      fl.delete();
      m_d16 = 0;
      m_d2  = 0;
      cyc   = 0;
    end else begin
      acc = in_valid && m_in_ready();
      pop = (mf.size() != 0) && out_ready;
      cyc++;
      if (pop) void'(mf.pop_front());
      while (fl.size() != 0 && (fl[0].t + 2 == cyc)) begin
        if (mf.size() >= DEPTH) begin
          errors++;
          $display("FAIL fifo_overflow occupancy=%0d limit=%0d", mf.size(), DEPTH);
        end
        e  = model_group(fl[0].d, fl[0].last);
        dr = model_drops(fl[0].d);
        mf.push_back(e);
        m_d16 = (m_d16 + dr > 65535) ? 65535 : m_d16 + dr;
        m_d2  = (m_d2 + dr > 3) ? 3 : m_d2 + dr;
        void'(fl.pop_front());
      end
      if (acc) fl.push_back('{d: dense_flat, last: in_last, t: cyc});
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(m_in_ready()));
    chk("out_valid", 32'(out_valid), 32'(mf.size() != 0));
    chk("busy", 32'(busy), 32'((mf.size() != 0) || (fl.size() != 0)));
    chk("dropped_nz", 32'(dropped_nz), 32'(m_d16));
    chk("sat_dropped_nz", 32'(s_dropped_nz), 32'(m_d2));
    if (mf.size() != 0) begin
      chk("weights_flat", 32'(weights_flat), 32'(mf[0].wts));
      chk("w_index", 32'(w_index), 32'(mf[0].idx));
      chk("out_last", 32'(out_last), 32'(mf[0].last));
      chk("sat_w_index", 32'(s_w_index), 32'(mf[0].idx));
    end else begin
      chk("empty_outputs", 32'({weights_flat, w_index, out_last}), 32'(0));
    end
    if (out_valid && out_ready) n_out++;
  end

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    in_valid = 1'b0;
    n_out = 0;
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
  endtask

  // Present one group at a falling edge and hold it until the credit allows it.
  task automatic push(input logic [15:0] d, input logic l);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    dense_flat = d;
    in_last = l;
    while (!m_in_ready() && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      errors++;
      $display("FAIL push_timeout group=%h waited=%0d cycles", d, guard);
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  logic [15:0] g [6];
  int          accepted;
  bit          rdy;
  time         t0;

  initial begin
    g[0] = 16'h1234; g[1] = 16'h8421; g[2] = 16'hF00F;
    g[3] = 16'h0A0B; g[4] = 16'h6666; g[5] = 16'h7E18;
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_dropped", 32'(dropped_nz), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_outputs", 32'({weights_flat, w_index, out_last}), 32'(0));

    // Basic prune
    out_ready = 1'b1;
    push(16'h3071, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("basic_w_index", 32'(w_index), 32'(4'b1010));
    chk("basic_weights", 32'(weights_flat), 32'(8'h37));
    chk("basic_last", 32'(out_last), 32'(1));
    chk("basic_dropped", 32'(dropped_nz), 32'(1));

    // Ties and zeros
    do_reset();
    push(16'h5555, 1'b0);
    push(16'h0000, 1'b1);
    @(negedge clk);
    chk("tie_w_index", 32'(w_index), 32'(4'b0011));
    chk("tie_weights", 32'(weights_flat), 32'(8'h55));
    chk("tie_dropped", 32'(dropped_nz), 32'(2));
    @(negedge clk);
    chk("zero_w_index", 32'(w_index), 32'(4'b0011));
    chk("zero_weights", 32'(weights_flat), 32'(8'h00));
    chk("zero_dropped", 32'(dropped_nz), 32'(2));
    chk("zero_last", 32'(out_last), 32'(1));

    // Backpressure
    do_reset();
    out_ready = 1'b0;
    accepted = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = (accepted < 6);
      dense_flat = g[accepted < 6 ? accepted : 5];
      in_last = (accepted == 5);
      rdy = m_in_ready();
      @(negedge clk);
      if (in_valid && rdy) accepted++;
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(accepted), 32'(4));
    chk("bp_in_ready", 32'(in_ready), 32'(0));
    chk("bp_head_weights", 32'(weights_flat), 32'(8'h34));
    chk("bp_head_w_index", 32'(w_index), 32'(4'b0011));
    out_ready = 1'b1;
    push(g[4], 1'b0);
    push(g[5], 1'b1);
    repeat (8) @(negedge clk);
    chk("bp_drained", 32'(busy), 32'(0));

    // Streaming throughput
    do_reset();
    out_ready = 1'b1;
    t0 = $time;
    for (int i = 0; i < 20; i++) begin
      chk("stream_in_ready", 32'(in_ready), 32'(1));
      push({4'(i), 4'(i * 3), 4'(15 - i), 4'(i ^ 5)}, (i % 4) == 3);
    end
    chk("stream_cycles", 32'(($time - t0) / 10), 32'(20));
    repeat (6) @(negedge clk);
    chk("stream_outputs", 32'(n_out), 32'(20));

    // Counter saturation (2-bit instance)
    do_reset();
    push(16'h1111, 1'b0);
    chk("sat_before0", 32'(s_dropped_nz), 32'(0));
    push(16'h1111, 1'b1);
    chk("sat_before1", 32'(s_dropped_nz), 32'(0));
    @(negedge clk);
    chk("sat_first", 32'(s_dropped_nz), 32'(2));
    @(negedge clk);
    chk("sat_second", 32'(s_dropped_nz), 32'(3));
    chk("wide_second", 32'(dropped_nz), 32'(4));
    repeat (3) @(negedge clk);
    chk("sat_hold", 32'(s_dropped_nz), 32'(3));

    // Mid-operation reset
    do_reset();
    out_ready = 1'b0;
    push(16'h1111, 1'b0);
    push(16'h3071, 1'b0);
    push(16'h5555, 1'b0);
    chk("mid_busy_before", 32'(busy), 32'(1));
    chk("mid_dropped_before", 32'(dropped_nz), 32'(2));
    #2 reset = 1'b1;
    #1;
    chk("mid_out_valid", 32'(out_valid), 32'(0));
    chk("mid_busy", 32'(busy), 32'(0));
    chk("mid_dropped", 32'(dropped_nz), 32'(0));
    chk("mid_sat_dropped", 32'(s_dropped_nz), 32'(0));
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    push(16'h0900, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("post_w_index", 32'(w_index), 32'(4'b0101));
    chk("post_weights", 32'(weights_flat), 32'(8'h90));
    chk("post_last", 32'(out_last), 32'(1));
    chk("post_dropped", 32'(dropped_nz), 32'(0));

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog elapsed=%0t limit=200000", $time);
    $fatal(1, "watchdog");
  end

endmodule
